// File: rtl/bus_controller.sv
// ---------------------------------------------------------------------------
// bus_controller
//
// Memory-side bus controller that sits directly behind the CPU bus port.
// It accepts one word request at a time, decodes the 27-bit word address
// into one of four targets and runs the access:
//   SDRAM   0x0000000-0x3FFFFFF  request/done handshake with a timeout
//   ROM     0x7000000-0x70003FF  synchronous read, writes are dropped
//   VRAM32  0x7100000-0x71003FF  synchronous read/write
//   I/O     0x7200000-0x72000FF  synchronous read/write
// Any other address is unmapped. Unmapped accesses and SDRAM timeouts
// complete with zero read data and set the sticky bus_err flag.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   bus_start/we/addr/data     CPU request, sampled only while idle
//   bus_q, bus_done            registered read data, one-cycle done pulse
//   bus_err                    sticky error flag, cleared only by reset
//   sdram_addr/d/we            SDRAM request fields, stable for the request
//   sdram_start                one-cycle SDRAM request pulse
//   sdram_q, sdram_done        SDRAM read data and completion pulse
//   rom_addr, rom_q            boot ROM port (1-cycle read latency)
//   vram_addr/d/we, vram_q     VRAM32 port (1-cycle read latency)
//   io_addr/d/we, io_q         I/O register port (1-cycle read latency)
//
// SDRAM_TIMEOUT (1..65535) is the number of cycles waited for sdram_done.
// ---------------------------------------------------------------------------
module bus_controller #(
    parameter int SDRAM_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        bus_start,
    input  logic        bus_we,
    input  logic [26:0] bus_addr,
    input  logic [31:0] bus_data,
    output logic [31:0] bus_q,
    output logic        bus_done,
    output logic        bus_err,

    output logic [25:0] sdram_addr,
    output logic [31:0] sdram_d,
    output logic        sdram_we,
    output logic        sdram_start,
    input  logic [31:0] sdram_q,
    input  logic        sdram_done,

    output logic [9:0]  rom_addr,
    input  logic [31:0] rom_q,

    output logic [9:0]  vram_addr,
    output logic [31:0] vram_d,
    output logic        vram_we,
    input  logic [31:0] vram_q,

    output logic [7:0]  io_addr,
    output logic [31:0] io_d,
    output logic        io_we,
    input  logic [31:0] io_q
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SDRAM_WAIT = 3'd1;
    localparam logic [2:0] ST_LOCAL      = 3'd2;
    localparam logic [2:0] ST_CAPTURE    = 3'd3;
    localparam logic [2:0] ST_UNMAPPED   = 3'd4;

    // Local (on-chip) targets, indexed the same way in every table below.
    localparam int         N_LOCAL  = 3;
    localparam logic [1:0] TGT_ROM  = 2'd0;
    localparam logic [1:0] TGT_VRAM = 2'd1;
    localparam logic [1:0] TGT_IO   = 2'd2;

    // Base address and window size (as an address-bit count) of each local
    // target. A window matches when every address bit above the window
    // equals the corresponding base bit.
    localparam logic [26:0] LOCAL_BASE [N_LOCAL] = '{27'h7000000, 27'h7100000, 27'h7200000};
    localparam int          LOCAL_BITS [N_LOCAL] = '{10, 10, 8};

    // The counter is compared against the limit on every waiting cycle; the
    // limit itself is reachable, hence the full 16-bit width.
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(SDRAM_TIMEOUT);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [2:0]  state_reg;
    logic [15:0] count_reg;
    logic        we_reg;     // latched direction of the access in flight
    logic [1:0]  tgt_reg;    // latched local target for LOCAL/CAPTURE

    // -----------------------------------------------------------------------
    // Address decode. It is evaluated on the request fields in the cycle
    // they are latched, so the chosen next state and target fields always
    // correspond to the latched address.
    // -----------------------------------------------------------------------
    logic [N_LOCAL-1:0] local_hit;
    logic               sdram_hit;

    assign sdram_hit = ~bus_addr[26];

    genvar gi;
    generate
        for (gi = 0; gi < N_LOCAL; gi++) begin : g_decode
            assign local_hit[gi] =
                (bus_addr >> LOCAL_BITS[gi]) == (LOCAL_BASE[gi] >> LOCAL_BITS[gi]);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Controller
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            we_reg      <= 1'b0;
            tgt_reg     <= TGT_ROM;
            bus_q       <= '0;
            bus_done    <= 1'b0;
            bus_err     <= 1'b0;
            sdram_addr  <= '0;
            sdram_d     <= '0;
            sdram_we    <= 1'b0;
            sdram_start <= 1'b0;
            rom_addr    <= '0;
            vram_addr   <= '0;
            vram_d      <= '0;
            vram_we     <= 1'b0;
            io_addr     <= '0;
            io_d        <= '0;
            io_we       <= 1'b0;
        end else begin
            // Pulse outputs default low; each state raises what it needs.
            bus_done    <= 1'b0;
            sdram_start <= 1'b0;
            vram_we     <= 1'b0;
            io_we       <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (bus_start) begin
                        we_reg <= bus_we;
                        if (sdram_hit) begin
                            // Request fields are registered here and left
                            // untouched until the access finishes.
                            sdram_addr  <= bus_addr[25:0];
                            sdram_d     <= bus_data;
                            sdram_we    <= bus_we;
                            sdram_start <= 1'b1;
                            count_reg   <= '0;
                            state_reg   <= ST_SDRAM_WAIT;
                        end else if (local_hit[TGT_ROM]) begin
                            // ROM is read-only: a write still runs the full
                            // local sequence but never raises a strobe.
                            rom_addr  <= bus_addr[9:0];
                            tgt_reg   <= TGT_ROM;
                            state_reg <= ST_LOCAL;
                        end else if (local_hit[TGT_VRAM]) begin
                            vram_addr <= bus_addr[9:0];
                            vram_d    <= bus_data;
                            vram_we   <= bus_we;
                            tgt_reg   <= TGT_VRAM;
                            state_reg <= ST_LOCAL;
                        end else if (local_hit[TGT_IO]) begin
                            io_addr   <= bus_addr[7:0];
                            io_d      <= bus_data;
                            io_we     <= bus_we;
                            tgt_reg   <= TGT_IO;
                            state_reg <= ST_LOCAL;
                        end else begin
                            state_reg <= ST_UNMAPPED;
                        end
                    end
                end

                ST_SDRAM_WAIT: begin
                    // sdram_done is checked before the limit so that a
                    // completion on the final cycle is not reported as a
                    // timeout.
                    if (sdram_done) begin
                        if (!we_reg) begin
                            bus_q <= sdram_q;
                        end
                        sdram_we  <= 1'b0;
                        bus_done  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else if (count_reg == TIMEOUT_LIMIT) begin
                        bus_q     <= '0;
                        bus_err   <= 1'b1;
                        sdram_we  <= 1'b0;
                        bus_done  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        count_reg <= count_reg + 16'd1;
                    end
                end

                ST_LOCAL: begin
                    // Address (and write strobe) are already on the port
                    // during this cycle; the target samples them at the end
                    // of it and presents read data in the next.
                    state_reg <= ST_CAPTURE;
                end

                ST_CAPTURE: begin
                    if (!we_reg) begin
                        case (tgt_reg)
                            TGT_ROM:  bus_q <= rom_q;
                            TGT_VRAM: bus_q <= vram_q;
                            default:  bus_q <= io_q;
                        endcase
                    end
                    bus_done  <= 1'b1;
                    state_reg <= ST_IDLE;
                end

                ST_UNMAPPED: begin
                    bus_q     <= '0;
                    bus_err   <= 1'b1;
                    bus_done  <= 1'b1;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
